// File: rtl/n64_vinfo_meas_pkg.sv
// Shared definitions for the N64 video-info extractor: state encoding,
// default thresholds, vinfo/sync bit positions and edge helpers.
package n64_vinfo_meas_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } vinfo_state_e;

  localparam int unsigned PAL_LINE_THRESH_DEF = 288;

  localparam int unsigned VINFO_PAL_BIT  = 1;
  localparam int unsigned VINFO_480I_BIT = 0;
  localparam logic [1:0]  VINFO_RESET    = 2'b01;

  localparam int unsigned SYNC_NV_BIT = 3;
  localparam int unsigned SYNC_NH_BIT = 1;

  function automatic logic rise(input logic pre, input logic cur);
    return ~pre & cur;
  endfunction

  function automatic logic fall(input logic pre, input logic cur);
    return pre & ~cur;
  endfunction

endpackage

// File: rtl/n64_vinfo_meas_if.sv
// Sync-sample inputs and measurement/mode outputs of n64_vinfo_meas.
interface n64_vinfo_meas_if #(
  parameter int unsigned LINE_CNT_W = 10,
  parameter int unsigned HLEN_W     = 12
);
  logic                  nVDSYNC;
  logic [3:0]            Sync_pre;
  logic [3:0]            Sync_cur;
  logic [1:0]            vinfo_o;
  logic                  field_id_o;
  logic [LINE_CNT_W-1:0] vlines_o;
  logic [HLEN_W-1:0]     hlen_o;
  logic                  vinfo_lock_o;
  logic                  vinfo_chg_o;

  modport master (
    output nVDSYNC, Sync_pre, Sync_cur,
    input  vinfo_o, field_id_o, vlines_o, hlen_o, vinfo_lock_o, vinfo_chg_o
  );

  modport slave (
    input  nVDSYNC, Sync_pre, Sync_cur,
    output vinfo_o, field_id_o, vlines_o, hlen_o, vinfo_lock_o, vinfo_chg_o
  );
endinterface

// File: rtl/n64_vinfo_meas_debounce.sv
// Mode debounce: holds the pending candidate, counts consistent fields,
// commits vinfo, and drops lock when vertical sync goes missing.
module n64_vinfo_debounce
  import n64_vinfo_meas_pkg::*;
#(
  parameter int unsigned LOCK_FIELDS = 3,
  parameter int unsigned TO_W        = 19
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       qual_i,
  input  logic       vs_pos_i,
  input  logic       cand_vld_i,
  input  logic [1:0] cand_i,
  output logic [1:0] vinfo_o,
  output logic       lock_o,
  output logic       chg_o
);
  localparam int unsigned SW = $clog2(LOCK_FIELDS + 1);

  vinfo_state_e    state_q, state_d;
  logic [1:0]      vinfo_q, vinfo_d, pend_q, pend_d;
  logic [SW-1:0]   stab_q, stab_d, stab_nx;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            chg_q, chg_d, timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_UNLOCKED;
      vinfo_q <= VINFO_RESET;
      pend_q  <= '0;
      stab_q  <= '0;
      wd_q    <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vinfo_q <= vinfo_d;
      pend_q  <= pend_d;
      stab_q  <= stab_d;
      wd_q    <= wd_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vinfo_d = vinfo_q;
    pend_d  = pend_q;
    stab_d  = stab_q;
    stab_nx = '0;
    wd_d    = wd_q;
    chg_d   = 1'b0;
    timeout = 1'b0;

    if (qual_i) begin
      if (vs_pos_i)        wd_d = '0;
      else if (wd_q != '1) wd_d = wd_q + TO_W'(1);
    end
    // A vsync rise clears the watchdog, so it can never coincide with a timeout.
    timeout = qual_i & ~vs_pos_i & (wd_d == '1);

    if (timeout) begin
      state_d = ST_UNLOCKED;
      stab_d  = '0;
    end else if (cand_vld_i) begin
      if (state_q == ST_LOCKED && cand_i == vinfo_q) begin
        stab_d = '0;
      end else begin
        stab_nx = (cand_i == pend_q) ? stab_q + SW'(1) : SW'(1);
        pend_d  = cand_i;
        if (32'(stab_nx) == LOCK_FIELDS) begin
          vinfo_d = cand_i;
          chg_d   = (cand_i != vinfo_q);
          state_d = ST_LOCKED;
          stab_d  = '0;
        end else begin
          stab_d  = stab_nx;
        end
      end
    end
  end

  assign vinfo_o = vinfo_q;
  assign lock_o  = (state_q == ST_LOCKED);
  assign chg_o   = chg_q;

endmodule

// File: rtl/n64_vinfo_meas.sv
// N64 video-info extractor: decodes sync edges on qualified samples, measures
// lines per field and samples per line, and feeds mode candidates to the debouncer.
module n64_vinfo_meas
  import n64_vinfo_meas_pkg::*;
#(
  parameter int unsigned LINE_CNT_W      = 10,
  parameter int unsigned HLEN_W          = 12,
  parameter int unsigned PAL_LINE_THRESH = PAL_LINE_THRESH_DEF,
  parameter int unsigned LOCK_FIELDS     = 3,
  parameter int unsigned TO_W            = 19
) (
  input logic             VCLK,
  input logic             RST,
  n64_vinfo_meas_if.slave bus
);
  logic qual, vs_pos, vs_neg, hs_pos, hs_neg;
  logic unused_sync;

  logic [LINE_CNT_W-1:0] lcnt_q, lcnt_d, vlines_q, vlines_d;
  logic [HLEN_W-1:0]     hcnt_q, hcnt_d, hlen_q, hlen_d;
  logic                  field_q, field_d, icand_q, icand_d;
  logic [1:0]            nfe_q, nfe_d;
  logic [1:0]            cand;
  logic                  cand_vld;
  logic [1:0]            vinfo;
  logic                  lock, chg;

  assign qual   = ~bus.nVDSYNC;
  assign vs_pos = qual & rise(bus.Sync_pre[SYNC_NV_BIT], bus.Sync_cur[SYNC_NV_BIT]);
  assign vs_neg = qual & fall(bus.Sync_pre[SYNC_NV_BIT], bus.Sync_cur[SYNC_NV_BIT]);
  assign hs_pos = qual & rise(bus.Sync_pre[SYNC_NH_BIT], bus.Sync_cur[SYNC_NH_BIT]);
  assign hs_neg = qual & fall(bus.Sync_pre[SYNC_NH_BIT], bus.Sync_cur[SYNC_NH_BIT]);
  assign unused_sync = ^{bus.Sync_pre[2], bus.Sync_pre[0], bus.Sync_cur[2], bus.Sync_cur[0]};

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      lcnt_q   <= '0;
      vlines_q <= '0;
      hcnt_q   <= '0;
      hlen_q   <= '0;
      field_q  <= 1'b0;
      icand_q  <= 1'b0;
      nfe_q    <= '0;
    end else begin
      lcnt_q   <= lcnt_d;
      vlines_q <= vlines_d;
      hcnt_q   <= hcnt_d;
      hlen_q   <= hlen_d;
      field_q  <= field_d;
      icand_q  <= icand_d;
      nfe_q    <= nfe_d;
    end
  end

  always_comb begin
    lcnt_d   = lcnt_q;
    vlines_d = vlines_q;
    hcnt_d   = hcnt_q;
    hlen_d   = hlen_q;
    field_d  = field_q;
    icand_d  = icand_q;
    nfe_d    = nfe_q;

    // nfe counts vsync falls (saturating at 2) so i_cand is trusted only
    // once a real previous field id exists.
    if (vs_neg) begin
      field_d = hs_neg;
      icand_d = hs_neg ^ field_q;
      if (nfe_q != 2'd2) nfe_d = nfe_q + 2'd1;
    end

    if (vs_pos) begin
      vlines_d = lcnt_q;
      lcnt_d   = '0;
    end else if (hs_pos && lcnt_q != '1) begin
      lcnt_d   = lcnt_q + LINE_CNT_W'(1);
    end

    if (hs_pos) begin
      hlen_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + HLEN_W'(1);
      hcnt_d = '0;
    end else if (qual && hcnt_q != '1) begin
      hcnt_d = hcnt_q + HLEN_W'(1);
    end
  end

  always_comb begin
    cand                 = '0;
    cand[VINFO_PAL_BIT]  = (32'(lcnt_q) >= PAL_LINE_THRESH);
    cand[VINFO_480I_BIT] = icand_q;
  end

  assign cand_vld = vs_pos & (nfe_q == 2'd2);

  n64_vinfo_debounce #(
    .LOCK_FIELDS (LOCK_FIELDS),
    .TO_W        (TO_W)
  ) u_deb (
    .clk_i      (VCLK),
    .rst_i      (RST),
    .qual_i     (qual),
    .vs_pos_i   (vs_pos),
    .cand_vld_i (cand_vld),
    .cand_i     (cand),
    .vinfo_o    (vinfo),
    .lock_o     (lock),
    .chg_o      (chg)
  );

  assign bus.vinfo_o      = vinfo;
  assign bus.field_id_o   = field_q;
  assign bus.vlines_o     = vlines_q;
  assign bus.hlen_o       = hlen_q;
  assign bus.vinfo_lock_o = lock;
  assign bus.vinfo_chg_o  = chg;

endmodule

// File: tb/tb_n64_vinfo_meas.sv
// Randomized field-level bench for n64_vinfo_meas with a behavioural mode model.
module tb_n64_vinfo_meas;
  localparam int unsigned LW0 = 10, HW0 = 12, LW1 = 8, HW1 = 2;
  localparam int unsigned TOW = 11, LOCKF = 3, THR = 288;
  localparam int unsigned H = 5, HS = 2;
  localparam int WD_MAX = (1 << TOW) - 1;
  localparam int L0MAX = (1 << LW0) - 1, L1MAX = (1 << LW1) - 1;
  localparam int H0MAX = (1 << HW0) - 1, H1MAX = (1 << HW1) - 1;

  logic clk = 1'b0;
  logic rst;
  logic nvd;
  logic [3:0] spre, scur, prev;
  int n_chk = 0, n_fail = 0, chg_seen = 0;

  always #5 clk = ~clk;

  n64_vinfo_meas_if #(.LINE_CNT_W(LW0), .HLEN_W(HW0)) bus0 ();
  n64_vinfo_meas_if #(.LINE_CNT_W(LW1), .HLEN_W(HW1)) bus1 ();
  assign bus0.nVDSYNC = nvd;
  assign bus0.Sync_pre = spre;
  assign bus0.Sync_cur = scur;
  assign bus1.nVDSYNC = nvd;
  assign bus1.Sync_pre = spre;
  assign bus1.Sync_cur = scur;

  n64_vinfo_meas #(.LINE_CNT_W(LW0), .HLEN_W(HW0), .PAL_LINE_THRESH(THR),
                   .LOCK_FIELDS(LOCKF), .TO_W(TOW))
    dut0 (.VCLK(clk), .RST(rst), .bus(bus0));
  n64_vinfo_meas #(.LINE_CNT_W(LW1), .HLEN_W(HW1), .PAL_LINE_THRESH(THR),
                   .LOCK_FIELDS(LOCKF), .TO_W(TOW))
    dut1 (.VCLK(clk), .RST(rst), .bus(bus1));

  always @(negedge clk) if (bus0.vinfo_chg_o) chg_seen++;

  // Reference model state
  logic [1:0] m_vinfo, m_pend;
  bit m_lock, m_fid, m_icand;
  int m_stab, m_nneg, m_lines, m_vl, m_wd, m_hs, m_hlen, m_chg = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_vinfo = 2'b01; m_pend = 2'b00; m_lock = 0; m_fid = 0; m_icand = 0;
    m_stab = 0; m_nneg = 0; m_lines = 0; m_vl = 0; m_wd = 0; m_hs = 0; m_hlen = 0;
  endtask

  task automatic model_debounce();
    int lines;
    logic [1:0] cand;
    lines = imin(m_vl, L0MAX);
    cand = {lines >= THR, m_icand};
    if (m_lock && cand == m_vinfo) m_stab = 0;
    else begin
      if (cand == m_pend) m_stab++;
      else begin m_pend = cand; m_stab = 1; end
      if (m_stab == LOCKF) begin
        if (cand != m_vinfo) m_chg++;
        m_vinfo = cand; m_lock = 1; m_stab = 0;
      end
    end
  endtask

  task automatic model_sample(input bit hr, input bit hf, input bit vr, input bit vf);
    m_hs++;
    if (hr) begin m_hlen = m_hs; m_hs = 0; end
    if (vf) begin
      m_icand = (hf != m_fid); m_fid = hf;
      if (m_nneg < 2) m_nneg++;
    end
    if (vr) begin
      m_vl = m_lines; m_lines = 0; m_wd = 0;
      if (m_nneg >= 2) model_debounce();
    end else begin
      if (hr) m_lines++;
      if (m_wd < WD_MAX) m_wd++;
      if (m_wd == WD_MAX) begin m_lock = 0; m_stab = 0; end
    end
  endtask

  task automatic emit(input bit v, input bit h, input bit hr, input bit hf, input bit vr, input bit vf);
    logic [3:0] cur;
    @(negedge clk);
    if ($urandom_range(0, 7) == 0) begin
      nvd = 1'b1; spre = 4'($urandom); scur = 4'($urandom);
      @(negedge clk);
    end
    cur = {v, 1'($urandom), h, 1'($urandom)};
    nvd = 1'b0; spre = prev; scur = cur; prev = cur;
    model_sample(hr, hf, vr, vf);
  endtask

  task automatic settle();
    @(negedge clk);
    nvd = 1'b1;
    #1;
  endtask

  task automatic check_all(input string tag);
    settle();
    chk({tag, ".vinfo"}, bus0.vinfo_o, m_vinfo);
    chk({tag, ".lock"}, bus0.vinfo_lock_o, m_lock);
    chk({tag, ".fid"}, bus0.field_id_o, m_fid);
    chk({tag, ".vlines"}, bus0.vlines_o, imin(m_vl, L0MAX));
    chk({tag, ".hlen"}, bus0.hlen_o, imin(m_hlen, H0MAX));
    chk({tag, ".chgcnt"}, chg_seen, m_chg);
    chk({tag, ".sat_vlines"}, bus1.vlines_o, imin(m_vl, L1MAX));
    chk({tag, ".sat_hlen"}, bus1.hlen_o, imin(m_hlen, H1MAX));
    chk({tag, ".sat_pal"}, bus1.vinfo_o[1], 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".vinfo"}, bus0.vinfo_o, 2'b01);
    chk({tag, ".fid"}, bus0.field_id_o, 0);
    chk({tag, ".vlines"}, bus0.vlines_o, 0);
    chk({tag, ".hlen"}, bus0.hlen_o, 0);
    chk({tag, ".lock"}, bus0.vinfo_lock_o, 0);
    chk({tag, ".chg"}, bus0.vinfo_chg_o, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    nvd = 1'b1; rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Field layout: vsync low from line 0 (offset 0 = odd, 3 = even) to line 3,
  // rising at sample 1 or, when coinc is set, together with the hsync rise.
  task automatic run_field(input int n, input bit odd, input bit coinc, input int rst_at);
    int vf, vr, idx;
    vf = odd ? 0 : 3;
    vr = 3 * H + (coinc ? HS : 1);
    for (int l = 0; l < n; l++) begin
      if (l == rst_at) mid_reset();
      for (int s = 0; s < int'(H); s++) begin
        idx = l * H + s;
        emit(!(idx >= vf && idx < vr), s >= HS, s == HS, s == 0, idx == vr, idx == vf);
      end
    end
  endtask

  task automatic stall(input int n);
    bit was_lock;
    for (int i = 0; i < n; i++) begin
      was_lock = m_lock;
      emit(1, 1, 0, 0, 0, 0);
      if (m_wd == WD_MAX - 1 || (was_lock && !m_lock)) begin
        settle();
        chk("wd_lock_edge", bus0.vinfo_lock_o, m_lock);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; nvd = 1'b1; spre = '0; scur = '0; prev = 4'b1111;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 5; f++) begin run_field(263, 0, 0, -1); check_all("ntsc240p"); end
    for (int f = 0; f < 5; f++) begin run_field((f % 2) ? 313 : 312, (f % 2) == 0, 0, -1); check_all("pal480i"); end
    for (int f = 0; f < 5; f++) begin run_field(263, 0, 0, -1); check_all("ntsc_back"); end
    run_field(313, 0, 0, -1); check_all("glitch");
    for (int f = 0; f < 2; f++) begin run_field(263, 0, 0, -1); check_all("glitch_resume"); end
    for (int f = 0; f < 4; f++) begin run_field(313, 0, 0, -1); check_all("pal240p"); end
    for (int f = 0; f < 4; f++) begin run_field(263, 0, 0, -1); check_all("ntsc_again"); end
    run_field(263, 0, 1, -1); check_all("coinc0");
    run_field(263, 0, 0, -1); check_all("coinc1");
    stall(WD_MAX);
    check_all("wd_stall");
    for (int f = 0; f < 4; f++) begin run_field(263, 0, 0, -1); check_all("wd_relock"); end
    for (int f = 0; f < 2; f++) begin run_field(300, 0, 0, -1); check_all("sat300"); end
    for (int f = 0; f < 3; f++) begin
      run_field(int'($urandom_range(200, 320)), 1'($urandom_range(0, 1)), 0, -1);
      check_all("rand");
    end
    run_field(263, 0, 0, 100); check_all("post_rst0");
    for (int f = 0; f < 2; f++) begin run_field(263, 0, 0, -1); check_all("post_rst"); end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/n64_vinfo_meas.md
# n64_vinfo_meas

Parametrised successor of the N64 video-info extractor in the PPU front end. Consumes the registered sync vectors (previous and current sample) qualified by nVDSYNC. Measures lines per field and samples per line, and derives the PAL/NTSC and 240p/480i modes from those measurements. The mode is committed only after it has been stable for a configurable number of fields, and a watchdog drops lock when vertical sync disappears.

## Interface
- LINE_CNT_W, 10: width of line counter and vlines_o
- HLEN_W, 12: width of per-line sample counter and hlen_o
- PAL_LINE_THRESH, 288: palmode candidate = 1 when measured lines per field ≥ this value
- LOCK_FIELDS, 3: consecutive fields with an identical new candidate required before commit (≥1)
- TO_W, 19: watchdog counter width; timeout when 2^TO_W−1 qualified samples pass without posedge nVSYNC
- VCLK  in  1  video clock
- RST  in  1  asynchronous, active-high reset
- nVDSYNC  in  1  low = qualified sample cycle; all state advances only when low
- Sync_pre  in  4  previous sync sample; [3] nVSYNC, [1] nHSYNC
- Sync_cur  in  4  current sync sample, same bit order
- vinfo_o  out  2  committed {palmode, n64_480i}
- field_id_o  out  1  last detected field: 0 even, 1 odd
- vlines_o  out  LINE_CNT_W  lines counted in last complete field
- hlen_o  out  HLEN_W  qualified samples in last complete line
- vinfo_lock_o  out  1  1 = LOCKED state
- vinfo_chg_o  out  1  one-VCLK pulse when vinfo_o changes value

## Operation
- Edge decode (qualified cycles only): posedge/negedge = Sync_pre bit differs from Sync_cur bit.
- Field detect at negedge nVSYNC:
  - coincident negedge nHSYNC → odd field, otherwise even;
  - i_cand = new field ≠ previous field_id; field_id_o <= new field.
- Line counter:
  - posedge nHSYNC increments, saturating at all-ones;
  - at posedge nVSYNC: vlines_o <= counter, counter <= 0; a coincident posedge nHSYNC is not counted;
  - p_cand = (counter ≥ PAL_LINE_THRESH), evaluated on the value captured at that edge.
- Line length: per-line counter increments every qualified sample, saturating. At posedge nHSYNC: hlen_o <= counter+1 (saturated), counter <= 0.
- Candidate {p_cand, i_cand} is evaluated once per field, at posedge nVSYNC.
- Debounce:
  - pend register holds the last differing candidate; stab_cnt counts consecutive fields with that candidate.
  - Candidate == vinfo_o (LOCKED) → stab_cnt <= 0.
  - Candidate ≠ vinfo_o, or state UNLOCKED:
    - candidate == pend → stab_cnt+1;
    - otherwise pend <= candidate, stab_cnt <= 1.
  - When stab_cnt reaches LOCK_FIELDS: vinfo_o <= pend, stab_cnt <= 0.
- FSM:
  - UNLOCKED → LOCKED on commit; vinfo_chg_o pulses only if the value actually differs.
  - LOCKED stays LOCKED on commit; vinfo_chg_o pulses.
  - Any state → UNLOCKED on watchdog timeout; stab_cnt <= 0; vinfo_o retained.
- Watchdog: cleared on every posedge nVSYNC, incremented each qualified sample, saturating; timeout = counter reaches all-ones.
- Reset values: vinfo_o = 2'b01, field_id_o = 0, vlines_o = 0, hlen_o = 0, vinfo_lock_o = 0, vinfo_chg_o = 0, all counters 0, state UNLOCKED.

## Timing
- All outputs are registered. Each update is visible on the VCLK after the qualified edge sample.
- vinfo_chg_o asserts in the same cycle vinfo_o takes its new value and lasts exactly 1 VCLK, regardless of nVDSYNC.
- Commit occurs at the posedge nVSYNC of the LOCK_FIELDS-th consistent field. Minimum latency from first new-mode field: LOCK_FIELDS fields.
- i_cand is only valid once two field edges have been seen. A freshly reset block therefore needs LOCK_FIELDS+1 fields before the first lock.
- Timeout and posedge nVSYNC in the same cycle: posedge wins, no timeout.
- RST mid-field: everything returns to reset values immediately, asynchronously. Counting restarts from 0, and the first partial field is measured as-is.
- nVDSYNC high cycles are ignored entirely; no counter moves.

## Structure
- Add to n64adv_vparams.vh: default thresholds (PAL_LINE_THRESH 288), FSM state encoding (UNLOCKED=0, LOCKED=1), vinfo bit indices.
- One sub-module: n64_vinfo_debounce (candidate, stab_cnt, pend, FSM, watchdog). Edge decode and measurement counters stay in the top level.

## Test plan
- NTSC 240p: 263 lines per field, all even fields, 773 samples per line → vlines_o=263, hlen_o=773; after 4 fields vinfo_o=2'b00, lock=1, one chg pulse.
- PAL 480i: alternating odd/even fields of 312/313 lines → vinfo_o=2'b11 after 4 fields; field_id_o toggles each field.
- Glitch rejection: locked at 2'b00, inject one 313-line field, then resume 263 → vinfo_o unchanged, no chg pulse; then 3 consecutive 313-line fields → commit to 2'b10 with one chg pulse.
- Watchdog with TO_W=8: stop nVSYNC while locked → lock drops after 255 qualified samples, vinfo_o held; resume sync → relock after 3 fields with no chg pulse (same mode).
- Saturation with LINE_CNT_W=8: 300-line field → vlines_o=255, p_cand=0 at threshold 288, counter does not wrap.
- Edge cases: RST asserted mid-field → all outputs at reset values next cycle. Coincident posedge nHSYNC/nVSYNC → that HSYNC is not counted in vlines_o.
